config_desc_fifo: RTL and testbench

CONFIG_DESC_FIFO -- requirements
Module: config_desc_fifo

---
 rtl/arbiter_pkg.sv | 25 ++
 rtl/config_desc_fifo.sv | 103 ++++++++++
 tb/tb_config_desc_fifo.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Constants shared by the descriptor FIFO and the arbiter that consumes it:
// the per-job field layout and the default widths.
package arbiter_pkg;

  localparam int DEF_CONFIG_WIDTH = 16;
  localparam int DEF_DEPTH        = 4;
  localparam int FIELDS_PER_JOB   = 8;

  localparam int FLD_PSUM_BURST    = 0;
  localparam int FLD_PSUM_ADDR     = 1;
  localparam int FLD_CONFIG_BURST  = 2;
  localparam int FLD_CONFIG_ADDR   = 3;
  localparam int FLD_WEIGHTS_BURST = 4;
  localparam int FLD_WEIGHTS_ADDR  = 5;
  localparam int FLD_ACT_BURST     = 6;
  localparam int FLD_ACT_ADDR      = 7;

  typedef logic [2:0] fld_idx_t;

  // Even field indices carry burst lengths; odd ones carry addresses.
  function automatic logic is_burst_fld(input fld_idx_t idx);
    return ~idx[0];
  endfunction

endpackage

// File: rtl/config_desc_fifo.sv
// Job FIFO for DMA descriptors: eight host words assemble one job in the tail
// slot, and only complete jobs become visible at the head.
module config_desc_fifo
  import arbiter_pkg::*;
#(
  parameter int CONFIG_WIDTH = DEF_CONFIG_WIDTH,
  parameter int DEPTH        = DEF_DEPTH
) (
  input  logic                        w_clock,
  input  logic                        w_reset_n,
  input  logic                        w_wr_valid,
  input  logic [CONFIG_WIDTH-1:0]     w_wr_data,
  output logic                        w_wr_ready,
  input  logic                        w_rd_en,
  output logic                        w_rd_valid,
  output logic [CONFIG_WIDTH-1:0]     w_burst_psum,
  output logic [CONFIG_WIDTH-1:0]     w_addr_psum,
  output logic [CONFIG_WIDTH-1:0]     w_burst_config,
  output logic [CONFIG_WIDTH-1:0]     w_addr_config,
  output logic [CONFIG_WIDTH-1:0]     w_burst_weights,
  output logic [CONFIG_WIDTH-1:0]     w_addr_weights,
  output logic [CONFIG_WIDTH-1:0]     w_burst_act,
  output logic [CONFIG_WIDTH-1:0]     w_addr_act,
  output logic [$clog2(DEPTH):0]      w_count,
  output logic                        w_err_zero_burst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("config_desc_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [CONFIG_WIDTH-1:0] mem_q [DEPTH][FIELDS_PER_JOB];
  logic [PW-1:0]           head_q, head_d;
  logic [PW-1:0]           tail_q, tail_d;
  fld_idx_t                fld_q, fld_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    err_q, err_d;

  logic wr_acc, commit, pop;

  assign w_wr_ready = w_reset_n && (count_q < CW'(DEPTH));
  assign w_rd_valid = w_reset_n && (count_q != '0);
  assign w_count    = count_q;
  assign w_err_zero_burst = err_q;

  assign wr_acc = w_wr_valid && w_wr_ready;
  assign commit = wr_acc && (fld_q == fld_idx_t'(FLD_ACT_ADDR));
  assign pop    = w_rd_en && w_rd_valid;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    fld_d   = fld_q;
    count_d = count_q;
    err_d   = err_q;
    if (wr_acc) begin
      fld_d = fld_q + fld_idx_t'(1);
      if (is_burst_fld(fld_q) && w_wr_data == '0) err_d = 1'b1;
    end
    if (commit) tail_d = tail_q + PW'(1);
    if (pop)    head_d = head_q + PW'(1);
    unique case ({commit, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge w_clock) begin
    if (!w_reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      fld_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fld_q   <= fld_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Slot storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge w_clock) begin
    if (wr_acc) mem_q[tail_q][fld_q] <= w_wr_data;
  end

  // An empty FIFO has head == tail, so gating on rd_valid also hides a partial job.
  assign w_burst_psum    = w_rd_valid ? mem_q[head_q][FLD_PSUM_BURST]    : '0;
  assign w_addr_psum     = w_rd_valid ? mem_q[head_q][FLD_PSUM_ADDR]     : '0;
  assign w_burst_config  = w_rd_valid ? mem_q[head_q][FLD_CONFIG_BURST]  : '0;
  assign w_addr_config   = w_rd_valid ? mem_q[head_q][FLD_CONFIG_ADDR]   : '0;
  assign w_burst_weights = w_rd_valid ? mem_q[head_q][FLD_WEIGHTS_BURST] : '0;
  assign w_addr_weights  = w_rd_valid ? mem_q[head_q][FLD_WEIGHTS_ADDR]  : '0;
  assign w_burst_act     = w_rd_valid ? mem_q[head_q][FLD_ACT_BURST]     : '0;
  assign w_addr_act      = w_rd_valid ? mem_q[head_q][FLD_ACT_ADDR]      : '0;

endmodule

// File: tb/tb_config_desc_fifo.sv
// Randomized and directed bench for config_desc_fifo against a queue-of-jobs model.
module tb_config_desc_fifo;

  localparam int W = 16;
  localparam int D = 4;

  typedef logic [7:0][W-1:0] job_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_ready;
  logic          rd_en = 1'b0;
  logic          rd_valid;
  logic [W-1:0]  b_psum, a_psum, b_cfg, a_cfg, b_wt, a_wt, b_act, a_act;
  logic [$clog2(D):0] count;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // model state
  job_t q[$];
  job_t partial;
  int   m_fld = 0;
  bit   m_err = 1'b0;

  config_desc_fifo #(.CONFIG_WIDTH(W), .DEPTH(D)) dut (
    .w_clock(clk), .w_reset_n(rst_n), .w_wr_valid(wr_valid), .w_wr_data(wr_data),
    .w_wr_ready(wr_ready), .w_rd_en(rd_en), .w_rd_valid(rd_valid),
    .w_burst_psum(b_psum), .w_addr_psum(a_psum), .w_burst_config(b_cfg),
    .w_addr_config(a_cfg), .w_burst_weights(b_wt), .w_addr_weights(a_wt),
    .w_burst_act(b_act), .w_addr_act(a_act), .w_count(count), .w_err_zero_burst(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Edge update of the model from the inputs presented before the edge.
  task automatic model_edge();
    bit acc, pp;
    if (!rst_n) begin
      q.delete();
      m_fld = 0;
      m_err = 1'b0;
      return;
    end
    acc = wr_valid && (q.size() < D);
    pp  = rd_en && (q.size() != 0);
    if (pp) void'(q.pop_front());
    if (acc) begin
      partial[m_fld] = wr_data;
      if ((m_fld % 2) == 0 && wr_data == 0) m_err = 1'b1;
      if (m_fld == 7) q.push_back(partial);
      m_fld = (m_fld + 1) % 8;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      automatic bit ev = rst_n && (q.size() != 0);
      automatic job_t h = ev ? q[0] : '0;
      chk("wr_ready", wr_ready, rst_n && (q.size() < D));
      chk("rd_valid", rd_valid, ev);
      chk("count", count, q.size());
      chk("err", err, m_err);
      chk("burst_psum", b_psum, h[0]);
      chk("addr_psum", a_psum, h[1]);
      chk("burst_config", b_cfg, h[2]);
      chk("addr_config", a_cfg, h[3]);
      chk("burst_weights", b_wt, h[4]);
      chk("addr_weights", a_wt, h[5]);
      chk("burst_act", b_act, h[6]);
      chk("addr_act", a_act, h[7]);
    end
  end

  // One clock: present inputs, take the edge, return just after the next negedge.
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit r, input bit rn);
    wr_valid = v; wr_data = d; rd_en = r; rst_n = rn;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic write_job(input logic [W-1:0] base);
    for (int i = 0; i < 8; i++) cyc(1'b1, base + W'(i) + 16'd1, 1'b0, 1'b1);
  endtask

  initial begin
    // reset
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cmp_en = 1'b1;
    chk("reset_count", count, 0);
    chk("reset_ready", wr_ready, 0);
    chk("reset_valid", rd_valid, 0);
    cyc(0, 0, 0, 1);
    chk("post_reset_ready", wr_ready, 1);
    chk("post_reset_err", err, 0);

    // first job, literal values
    begin
      logic [W-1:0] wds [8];
      wds = '{16'd16, 16'h100, 16'd8, 16'h200, 16'd4, 16'h300, 16'd2, 16'h400};
      for (int i = 0; i < 8; i++) begin
        cyc(1, wds[i], 0, 1);
        if (i == 6) chk("partial_hidden", rd_valid, 0);
      end
    end
    chk("j1_valid", rd_valid, 1);
    chk("j1_count", count, 1);
    chk("j1_psum", b_psum, 16);
    chk("j1_addr_act", a_act, 16'h400);
    chk("j1_burst_wt", b_wt, 4);

    // fill to full, then full-pop with a concurrent write attempt
    for (int j = 0; j < 3; j++) write_job(16'h1000 * (j + 1));
    chk("full_ready", wr_ready, 0);
    chk("full_count", count, 4);
    cyc(1, 16'h7777, 1, 1);
    chk("fullpop_count", count, 3);
    chk("fullpop_ready", wr_ready, 1);
    chk("fullpop_head", b_psum, 16'h1001);

    // drain to one job, then commit+pop on the same edge
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    chk("one_left", count, 1);
    for (int i = 0; i < 7; i++) cyc(1, 16'h5000 + W'(i) + 16'd1, 0, 1);
    cyc(1, 16'h5008, 1, 1);
    chk("cp_count", count, 1);
    chk("cp_head", b_psum, 16'h5001);
    chk("cp_head_addr_act", a_act, 16'h5008);
    cyc(0, 0, 1, 1);

    // reset mid-assembly
    for (int i = 0; i < 5; i++) cyc(1, 16'h0BAD, 0, 1);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 16'hA0 + W'(i), 0, 1);
    chk("mid_rst_count", count, 1);
    chk("mid_rst_psum", b_psum, 16'hA0);
    cyc(0, 0, 1, 1);

    // zero weights burst, sticky until reset
    for (int i = 0; i < 8; i++) cyc(1, (i == 4) ? 16'd0 : 16'h30 + W'(i), 0, 1);
    chk("zero_burst_err", err, 1);
    chk("zero_burst_stored", b_wt, 0);
    cyc(0, 0, 1, 1);
    chk("err_after_pop", err, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("err_cleared", err, 0);

    // reads on empty
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1);
    chk("empty_rd_count", count, 0);
    write_job(16'h6000);
    chk("after_empty_psum", b_psum, 16'h6001);
    chk("after_empty_addr_act", a_act, 16'h6008);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      automatic bit v  = ($urandom_range(9) < 7);
      automatic bit r  = ($urandom_range(9) < 4);
      automatic bit rn = ($urandom_range(299) != 0);
      automatic logic [W-1:0] d = ($urandom_range(15) == 0) ? '0 : W'($urandom);
      cyc(v, d, r, rn);
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
